mult32x32_req_ctrl: RTL and testbench

Valid/ready front-end that sits directly upstream of the fast 32x32 multiplier core (FSM plus datapath). It buffers operand pairs in a small FIFO and launches the core with a one-cycle start pulse. It holds the operands stable while the core is busy, then captures the 64-bit product into an output register with a valid/ready handshake. Operations complete strictly in order, one at a time.

---
 rtl/mult32x32_pkg.sv | 20 ++
 rtl/mult_req_fifo.sv | 56 +++++
 rtl/mult32x32_req_ctrl.sv | 155 +++++++++++++++
 tb/tb_mult32x32_req_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult32x32_pkg.sv
// ---------------------------------------------------------------------------
// mult32x32_pkg
// Shared types and widths for the 32x32 multiplier request front-end.
//   req_state_t : request FSM states (IDLE, LAUNCH, WAIT, HOLD)
//   OP_W        : operand width of the multiplier core
//   PROD_W      : product width of the multiplier core
// ---------------------------------------------------------------------------
package mult32x32_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } req_state_t;

endpackage

// File: rtl/mult_req_fifo.sv
// ---------------------------------------------------------------------------
// mult_req_fifo
// Synchronous FIFO for operand pairs. Full/empty are resolved with an extra
// pointer MSB, so every one of DEPTH entries is usable.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_data     : write request and data (ignored when full)
//   pop                 : read request (ignored when empty)
//   pop_data            : head entry, valid whenever !empty
//   full, empty         : occupancy flags
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module mult_req_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mult32x32_req_ctrl.sv
// ---------------------------------------------------------------------------
// mult32x32_req_ctrl
// Valid/ready front-end for the fast 32x32 multiplier core. Operand pairs are
// queued in a FIFO, launched one at a time with a single-cycle start pulse,
// and the 64-bit product is captured into an output register.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   in_valid/in_ready         : operand pair handshake (in_ready = !fifo_full)
//   in_a, in_b                : operands
//   out_valid/out_ready       : product handshake
//   out_product               : registered unsigned product a*b
//   mult_start                : one-cycle start pulse to the core
//   mult_busy                 : core busy indication
//   mult_a, mult_b            : registered operands to the core
//   mult_product              : core product register
//   perf_ops, perf_busy_cycles: counters, only with MULT_REQ_PERF_EN defined
// Optional feature macro: MULT_REQ_PERF_EN
// ---------------------------------------------------------------------------
module mult32x32_req_ctrl
    import mult32x32_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned A_W        = OP_W,
    parameter int unsigned B_W        = OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [A_W-1:0]    in_a,
    input  logic [B_W-1:0]    in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              mult_start,
    input  logic              mult_busy,
    output logic [A_W-1:0]    mult_a,
    output logic [B_W-1:0]    mult_b,
`ifdef MULT_REQ_PERF_EN
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_busy_cycles,
`endif
    input  logic [PROD_W-1:0] mult_product
);

    req_state_t           state;
    req_state_t           state_next;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [A_W+B_W-1:0]   fifo_rdata;
    logic                 capture;

    // No bypass: a pop in the same cycle does not open in_ready on a full FIFO.
    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && !fifo_full;
    assign mult_start = (state == LAUNCH);

    mult_req_fifo #(
        .WIDTH (A_W + B_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                // Core raises busy the cycle after start, so busy low here means done.
                if (!mult_busy) begin
                    if (!out_valid || out_ready) begin
                        capture    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // Core keeps its product while start stays low.
                if (out_ready) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands only change on a pop, so they stay stable until capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mult_a <= '0;
            mult_b <= '0;
        end else if (fifo_pop) begin
            {mult_a, mult_b} <= fifo_rdata;
        end
    end

    // A capture coinciding with a drain keeps out_valid high with the new product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_product <= '0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_product <= mult_product;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef MULT_REQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops         <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (capture)   perf_ops         <= perf_ops + 32'd1;
            if (mult_busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult32x32_req_ctrl.sv
// Self-checking bench for mult32x32_req_ctrl: behavioural core model,
// scoreboard queue of expected products, directed and random stimulus.
module tb_mult32x32_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic        mult_start;
    logic        mult_busy;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [63:0] mult_product;
`ifdef MULT_REQ_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_busy_cycles;
`endif

    int          total_checks  = 0;
    int          passed_checks = 0;
    int          start_cnt     = 0;
    logic        prev_start    = 1'b0;
    logic [63:0] exp_q[$];
    logic        rand_run;

    always #5 clk = ~clk;

    mult32x32_req_ctrl #(
        .FIFO_DEPTH (2),
        .A_W        (32),
        .B_W        (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .mult_start       (mult_start),
        .mult_busy        (mult_busy),
        .mult_a           (mult_a),
        .mult_b           (mult_b),
`ifdef MULT_REQ_PERF_EN
        .perf_ops         (perf_ops),
        .perf_busy_cycles (perf_busy_cycles),
`endif
        .mult_product     (mult_product)
    );

    // Core busy length from the operand upper halves.
    function automatic int busy_len(input logic [31:0] a, input logic [31:0] b);
        int zeros;
        zeros = int'(a[31:16] == 16'h0) + int'(b[31:16] == 16'h0);
        if (zeros == 2) return 1;
        if (zeros == 1) return 2;
        return 4;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'h0, a};
        wb = {32'h0, b};
        return wa * wb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_checks++;
        if (act === req) passed_checks++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Behavioural multiplier core: busy from the cycle after start; the product
    // only becomes valid when busy falls.
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    int          core_cnt;
    logic        core_busy;
    logic [63:0] core_prod;
    assign mult_busy    = core_busy;
    assign mult_product = core_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_prod <= '0;
            core_cnt  <= 0;
            lat_a     <= '0;
            lat_b     <= '0;
        end else if (mult_start) begin
            core_busy <= 1'b1;
            core_cnt  <= busy_len(mult_a, mult_b) - 1;
            lat_a     <= mult_a;
            lat_b     <= mult_b;
            core_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (core_busy) begin
            if (core_cnt == 0) begin
                core_busy <= 1'b0;
                core_prod <= ref_mul(lat_a, lat_b);
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Monitor: start pulse sanity, operand stability, scoreboard drain.
    always @(negedge clk) begin
        if (!reset) begin
            if (mult_start) begin
                start_cnt++;
                check("start_single_cycle", {63'h0, prev_start}, 64'h0);
            end
            prev_start = mult_start;
            if (core_busy) begin
                check("mult_a_stable", {32'h0, mult_a}, {32'h0, lat_a});
                check("mult_b_stable", {32'h0, mult_b}, {32'h0, lat_b});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'h1, 64'h0);
                end else begin
                    check("out_product", out_product, exp_q.pop_front());
                end
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("push_timeout", 64'h0, 64'h1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(ref_mul(a, b));
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'h0);
    endtask

    int exp_ops  = 0;
    int exp_busy = 0;

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b);
        int n;
        int s0;
        s0 = start_cnt;
        push(a, b);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(busy_len(a, b) + 4));
        check({name, "_product"}, out_product, ref_mul(a, b));
        @(posedge clk);
        #1;
        check({name, "_start_pulses"}, 64'(start_cnt - s0), 64'd1);
        exp_ops++;
        exp_busy += busy_len(a, b);
    endtask

    initial begin
        int s0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        rand_run  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_out_valid",   {63'h0, out_valid},  64'h0);
        check("rst_in_ready",    {63'h0, in_ready},   64'h1);
        check("rst_mult_start",  {63'h0, mult_start}, 64'h0);
        check("rst_mult_a",      {32'h0, mult_a},     64'h0);
        check("rst_mult_b",      {32'h0, mult_b},     64'h0);
        check("rst_out_product", out_product,         64'h0);

        // Directed latency cases with an empty pipe.
        out_ready = 1'b1;
        directed("small",    32'h0000_0003, 32'h0000_0005);
        directed("max",      32'hFFFF_FFFF, 32'hFFFF_FFFF);
        directed("one_msw",  32'h0001_0000, 32'h0000_0002);
`ifdef MULT_REQ_PERF_EN
        check("perf_ops",         {32'h0, perf_ops},         64'(exp_ops));
        check("perf_busy_cycles", {32'h0, perf_busy_cycles}, 64'(exp_busy));
`endif

        // Back-pressure: three pairs with the consumer stalled.
        out_ready = 1'b0;
        s0 = start_cnt;
        push(32'h0000_0011, 32'h0000_0022);
        push(32'h0003_0000, 32'h0004_0000);
        push(32'h1234_5678, 32'h0000_0009);
        check("bp_in_ready_full", {63'h0, in_ready}, 64'h0);
        repeat (30) @(posedge clk);
        #1;
        check("bp_out_valid_held", {63'h0, out_valid}, 64'h1);
        check("bp_head_product",   out_product, ref_mul(32'h0000_0011, 32'h0000_0022));
        check("bp_two_launched",   64'(start_cnt - s0), 64'd2);
        check("bp_in_ready_open",  {63'h0, in_ready}, 64'h1);
        out_ready = 1'b1;
        wait_drained("bp_drained");
        check("bp_all_launched", 64'(start_cnt - s0), 64'd3);

        // Reset while WAIT with two entries queued.
        s0 = start_cnt;
        push(32'hFFFF_0001, 32'h8000_0000);
        push(32'h0000_0007, 32'h0000_0008);
        push(32'h0000_0009, 32'h0000_000A);
        check("rw_core_busy", {63'h0, mult_busy}, 64'h1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rw_out_valid",  {63'h0, out_valid},  64'h0);
        check("rw_mult_start", {63'h0, mult_start}, 64'h0);
        check("rw_in_ready",   {63'h0, in_ready},   64'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        s0 = start_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("rw_no_launch",     64'(start_cnt - s0), 64'd0);
        check("rw_no_out_valid",  {63'h0, out_valid},  64'h0);
        directed("after_reset", 32'h0002_0000, 32'h0003_0000);

        // Random traffic with random consumer back-pressure.
        s0 = start_cnt;
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a;
                    logic [31:0] b;
                    int          mode;
                    a    = $urandom;
                    b    = $urandom;
                    mode = $urandom_range(0, 2);
                    if (mode == 0) begin
                        a[31:16] = 16'h0;
                        b[31:16] = 16'h0;
                    end else if (mode == 1) begin
                        if ($urandom_range(0, 1) == 1) a[31:16] = 16'h0;
                        else b[31:16] = 16'h0;
                    end
                    push(a, b);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drained("rand_drained");
        check("rand_launches", 64'(start_cnt - s0), 64'd40);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
